// File: rtl/vector_register_file_pkg.sv
// Shared vector geometry and lane-level types for the vector datapath.
package vector_register_file_pkg;

   localparam int unsigned VEC_DATA_WIDTH = 8;
   localparam int unsigned VEC_LANES      = 6;
   localparam int unsigned VEC_REG_COUNT  = 8;
   localparam int unsigned VEC_ADDR_WIDTH = 3;

   typedef logic [VEC_DATA_WIDTH-1:0]   vec_lane_t;
   typedef vec_lane_t [VEC_LANES-1:0]   vec_t;
   typedef logic [VEC_LANES-1:0]        vec_mask_t;

endpackage : vector_register_file_pkg

// File: rtl/vector_read_bypass.sv
// One read port: out-of-range reads return zero, otherwise each lane takes
// the in-flight write lane when the write hits this register and the lane is
// enabled, or the stored lane when it is not.
module vector_read_bypass
   import vector_register_file_pkg::*;
#(
   parameter int unsigned REG_COUNT  = VEC_REG_COUNT,
   parameter int unsigned ADDR_WIDTH = VEC_ADDR_WIDTH
) (
   input  logic                  rst,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [ADDR_WIDTH-1:0] raddr,
   input  vec_t                  wdataVec,
   input  vec_mask_t             wmask,
   input  vec_t                  regData,
   output vec_t                  rdata
);

   localparam logic [ADDR_WIDTH:0] REG_LIMIT = (ADDR_WIDTH+1)'(REG_COUNT);

   logic readValid;
   logic bypassHit;

   // Decide whether the read is legal and whether the current write forwards to it
   always_comb begin
      readValid = ({1'b0, raddr} < REG_LIMIT);
      bypassHit = !rst && we && ({1'b0, waddr} < REG_LIMIT) && (raddr == waddr);
   end

   // Per-lane merge of forwarded write data and stored data
   for (genvar i = 0; i < VEC_LANES; i++) begin : gLane
      assign rdata[i] = !readValid               ? '0          :
                        (bypassHit && wmask[i])  ? wdataVec[i] :
                                                   regData[i];
   end

endmodule : vector_read_bypass

// File: rtl/vector_register_file.sv
// Vector register file feeding the vector ALU: two combinational read ports
// with write-to-read bypass, one lane-masked write port, sticky write-address
// error flag.
module vector_register_file
   import vector_register_file_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = VEC_DATA_WIDTH,
   parameter int unsigned LANES      = VEC_LANES,
   parameter int unsigned REG_COUNT  = VEC_REG_COUNT,
   parameter int unsigned ADDR_WIDTH = VEC_ADDR_WIDTH
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [ADDR_WIDTH-1:0]            raddr1,
   input  logic [ADDR_WIDTH-1:0]            raddr2,
   output logic [LANES-1:0][DATA_WIDTH-1:0] rdata1,
   output logic [LANES-1:0][DATA_WIDTH-1:0] rdata2,
   input  logic                             we,
   input  logic [ADDR_WIDTH-1:0]            waddr,
   input  logic [DATA_WIDTH*LANES-1:0]      wdata,
   input  logic [LANES-1:0]                 wmask,
   output logic                             waddr_err
);

   localparam logic [ADDR_WIDTH:0] REG_LIMIT = (ADDR_WIDTH+1)'(REG_COUNT);

   vec_t regs [REG_COUNT];
   vec_t wdataVec;
   vec_t regData1;
   vec_t regData2;
   vec_t mergedData1;
   vec_t mergedData2;
   logic writeValid;

   assign wdataVec   = wdata;
   assign writeValid = ({1'b0, waddr} < REG_LIMIT);

   // Fetch stored operands; out-of-range indices never touch the array
   always_comb begin
      regData1 = '0;
      regData2 = '0;
      if ({1'b0, raddr1} < REG_LIMIT) regData1 = regs[raddr1];
      if ({1'b0, raddr2} < REG_LIMIT) regData2 = regs[raddr2];
   end

   vector_read_bypass #(
      .REG_COUNT  (REG_COUNT),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) uReadBypass1 (
      .rst      (rst),
      .we       (we),
      .waddr    (waddr),
      .raddr    (raddr1),
      .wdataVec (wdataVec),
      .wmask    (wmask),
      .regData  (regData1),
      .rdata    (mergedData1)
   );

   vector_read_bypass #(
      .REG_COUNT  (REG_COUNT),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) uReadBypass2 (
      .rst      (rst),
      .we       (we),
      .waddr    (waddr),
      .raddr    (raddr2),
      .wdataVec (wdataVec),
      .wmask    (wmask),
      .regData  (regData2),
      .rdata    (mergedData2)
   );

   assign rdata1 = mergedData1;
   assign rdata2 = mergedData2;

   // Array update and sticky error flag; reset wins over any write that cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < int'(REG_COUNT); i++) regs[i] <= '0;
         waddr_err <= 1'b0;
      end else if (we) begin
         if (writeValid) begin
            for (int i = 0; i < int'(VEC_LANES); i++) begin
               if (wmask[i]) regs[waddr][i] <= wdataVec[i];
            end
         end else begin
            waddr_err <= 1'b1;
         end
      end
   end

endmodule : vector_register_file

// File: tb/tb_vector_register_file.sv
module tb_vector_register_file;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  raddr1, raddr2, waddr;
   logic        we;
   logic [47:0] wdata;
   logic [5:0]  wmask;

   logic [5:0][7:0] rdata1, rdata2, rdata1S, rdata2S;
   logic            waddrErr, waddrErrS;

   int passCount = 0;
   int checkCount = 0;

   always #5 clk = ~clk;

   vector_register_file dut (
      .clk(clk), .rst(rst), .raddr1(raddr1), .raddr2(raddr2),
      .rdata1(rdata1), .rdata2(rdata2), .we(we), .waddr(waddr),
      .wdata(wdata), .wmask(wmask), .waddr_err(waddrErr)
   );

   vector_register_file #(.REG_COUNT(6)) dutSmall (
      .clk(clk), .rst(rst), .raddr1(raddr1), .raddr2(raddr2),
      .rdata1(rdata1S), .rdata2(rdata2S), .we(we), .waddr(waddr),
      .wdata(wdata), .wmask(wmask), .waddr_err(waddrErrS)
   );

   // Reference model of the 8-register instance: registers as byte arrays
   logic [7:0] mem [8][6];
   logic       errModel;

   task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
      checkCount++;
      if (act === exp) passCount++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   function automatic logic [47:0] modelRead(input int ra);
      logic [47:0] r;
      r = '0;
      if (ra >= 8) return r;
      for (int l = 0; l < 6; l++) begin
         if (!rst && we && int'(waddr) == ra && wmask[l]) r[l*8 +: 8] = wdata[l*8 +: 8];
         else                                            r[l*8 +: 8] = mem[ra][l];
      end
      return r;
   endfunction

   task automatic modelEdge();
      if (rst) begin
         for (int r = 0; r < 8; r++) for (int l = 0; l < 6; l++) mem[r][l] = 8'h00;
         errModel = 1'b0;
      end else if (we) begin
         for (int l = 0; l < 6; l++) if (wmask[l]) mem[waddr][l] = wdata[l*8 +: 8];
      end
   endtask

   // Advance one clock; inputs are changed and outputs sampled 1 time unit after the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic        rst, we;
      logic [2:0]  waddr, raddr1, raddr2;
      logic [5:0]  wmask;
      logic [47:0] wdata;
      logic [47:0] exp1, exp2;
      logic        expErr;
   } vecRec_t;

   vecRec_t tbl [10];

   initial begin
      rst = 1'b1; we = 1'b0; waddr = '0; raddr1 = '0; raddr2 = '0;
      wdata = '0; wmask = '0;
      tick();
      rst = 1'b0;
      #2;

      // Reset sweep: every register reads zero, no error
      for (int a = 0; a < 8; a++) begin
         raddr1 = 3'(a); raddr2 = 3'(7 - a);
         #1;
         check($sformatf("reset_rd1_r%0d", a), rdata1, 48'h0);
         check($sformatf("reset_rd2_r%0d", 7 - a), rdata2, 48'h0);
      end
      check("reset_err", 48'(waddrErr), 48'h0);

      // Directed table: rdata is checked before the edge, err after it
      tbl[0] = '{1'b0, 1'b1, 3'd3, 3'd3, 3'd0, 6'h3F, 48'h060504030201, 48'h060504030201, 48'h0, 1'b0};
      tbl[1] = '{1'b0, 1'b0, 3'd0, 3'd3, 3'd3, 6'h00, 48'h0, 48'h060504030201, 48'h060504030201, 1'b0};
      tbl[2] = '{1'b0, 1'b1, 3'd3, 3'd3, 3'd5, 6'b000101, 48'hAAAAAAAAAAAA, 48'h060504AA02AA, 48'h0, 1'b0};
      tbl[3] = '{1'b0, 1'b0, 3'd0, 3'd3, 3'd3, 6'h00, 48'h0, 48'h060504AA02AA, 48'h060504AA02AA, 1'b0};
      tbl[4] = '{1'b0, 1'b1, 3'd2, 3'd2, 3'd2, 6'b110000, 48'h111111111111, 48'h111100000000, 48'h111100000000, 1'b0};
      tbl[5] = '{1'b0, 1'b0, 3'd0, 3'd2, 3'd3, 6'h00, 48'h0, 48'h111100000000, 48'h060504AA02AA, 1'b0};
      tbl[6] = '{1'b0, 1'b1, 3'd4, 3'd4, 3'd4, 6'h00, 48'hFFFFFFFFFFFF, 48'h0, 48'h0, 1'b0};
      tbl[7] = '{1'b0, 1'b0, 3'd0, 3'd4, 3'd7, 6'h00, 48'h0, 48'h0, 48'h0, 1'b0};
      tbl[8] = '{1'b1, 1'b1, 3'd1, 3'd1, 3'd3, 6'h3F, 48'hFFFFFFFFFFFF, 48'h0, 48'h060504AA02AA, 1'b0};
      tbl[9] = '{1'b0, 1'b0, 3'd0, 3'd1, 3'd3, 6'h00, 48'h0, 48'h0, 48'h0, 1'b0};

      for (int i = 0; i < 10; i++) begin
         rst = tbl[i].rst; we = tbl[i].we; waddr = tbl[i].waddr;
         raddr1 = tbl[i].raddr1; raddr2 = tbl[i].raddr2;
         wmask = tbl[i].wmask; wdata = tbl[i].wdata;
         #2;
         check($sformatf("tbl%0d_rd1", i), rdata1, tbl[i].exp1);
         check($sformatf("tbl%0d_rd2", i), rdata2, tbl[i].exp2);
         tick();
         check($sformatf("tbl%0d_err", i), 48'(waddrErr), 48'(tbl[i].expErr));
      end

      // Out-of-range writes on the 6-register instance
      rst = 1'b1; we = 1'b0;
      tick();
      rst = 1'b0; we = 1'b1; waddr = 3'd5; wmask = 6'h3F; wdata = 48'hC5C4C3C2C1C0;
      tick();
      waddr = 3'd6; wdata = 48'hDEADBEEFCAFE;
      raddr1 = 3'd6; raddr2 = 3'd5;
      #2;
      check("oor_bypass_rd1", rdata1S, 48'h0);
      check("oor_bypass_rd2", rdata2S, 48'hC5C4C3C2C1C0);
      tick();
      check("oor6_err_small", 48'(waddrErrS), 48'h1);
      check("oor6_err_main", 48'(waddrErr), 48'h0);
      waddr = 3'd7; raddr1 = 3'd7;
      tick();
      we = 1'b0;
      #2;
      check("oor7_rd1_zero", rdata1S, 48'h0);
      check("oor_reg5_held", rdata2S, 48'hC5C4C3C2C1C0);
      tick();
      tick();
      check("oor_err_sticky", 48'(waddrErrS), 48'h1);
      check("main_reg7_written", rdata1, 48'hDEADBEEFCAFE);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("oor_err_cleared", 48'(waddrErrS), 48'h0);

      // Randomized run against the byte-array model
      rst = 1'b1;
      tick();
      modelEdge();
      rst = 1'b0;
      for (int c = 0; c < 400; c++) begin
         rst    = ($urandom_range(0, 19) == 0);
         we     = ($urandom_range(0, 3) != 0);
         waddr  = 3'($urandom_range(0, 7));
         raddr1 = ($urandom_range(0, 2) == 0) ? waddr : 3'($urandom_range(0, 7));
         raddr2 = ($urandom_range(0, 2) == 0) ? waddr : 3'($urandom_range(0, 7));
         wmask  = 6'($urandom);
         wdata  = {16'($urandom), 32'($urandom)};
         #2;
         check($sformatf("rnd%0d_rd1", c), rdata1, modelRead(int'(raddr1)));
         check($sformatf("rnd%0d_rd2", c), rdata2, modelRead(int'(raddr2)));
         modelEdge();
         tick();
         check($sformatf("rnd%0d_err", c), 48'(waddrErr), 48'(errModel));
      end

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule : tb_vector_register_file
